seven_seg_capture: RTL and testbench
====================================

Name: seven_seg_capture

Overview:
- Receive-side counterpart of the hex-to-seven-segment encoder.
- Samples a multiplexed, active-low seven-segment display bus, made of segment lines plus one-hot anode enables.
- Waits for each digit's pattern to be stable, then decodes it back to a 4-bit hex value and stores it per digit position.
- Used as a display monitor or self-check probe: it sits in parallel with the display driver outputs and feeds a status or debug readout.

Parameters:
- DIGITS, 4: number of multiplexed digit positions, i.e. the width of an_n. Legal range 1..8.
- STABLE_CYCLES, 4: number of consecutive identical samples required before a capture. Legal range 2..255.

Ports:
- clk  input  1  single clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- seg_n  input  7  active-low segments. Bit 0 = a, bit 1 = b, …, bit 6 = g.
- an_n  input  DIGITS  active-low anode enables; bit i selects digit i.
- hex_out  output  4*DIGITS  captured hex values; digit i is hex_out[4i+3:4i].
- digit_valid  output  DIGITS  1 = slot i holds a decoded value.
- upd_valid  output  1  one-cycle pulse when a slot is written.
- upd_idx  output  3  slot index qualified by upd_valid.
- upd_hex  output  4  value qualified by upd_valid.
- code_err  output  1  one-cycle pulse when a stable pattern is not a legal glyph.

Behaviour:
- Reset:
  - hex_out = 0, digit_valid = 0, upd_valid = 0, upd_idx = 0, upd_hex = 0, code_err = 0.
  - Sample register = all ones (display dark), cnt = 0, state = IDLE.
  - Reset mid-settle discards the window; no capture follows until a fresh stable window completes.
- Input stage: {an_n, seg_n} is registered every cycle into s_q. "Change" means s_q differs from its previous value.
- Glyph table (active-high gfedcba; seg_n is the bitwise inverse):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Blank = 00, i.e. seg_n = 7F.
- FSM states IDLE, SETTLE, HOLD. Evaluated each cycle on s_q:
  - Change with exactly one an_n bit low: go to SETTLE, cnt = 0.
  - Change with zero or more than one anode low: go to IDLE, cnt = 0. IDLE never captures.
  - SETTLE with no change: cnt increments. When cnt == STABLE_CYCLES-1, perform the capture action and go to HOLD.
  - HOLD: no further action until a change. The same pattern is never captured twice in one window.
- Capture action, registered and visible after the edge that completes the window. idx is the position of the low an_n bit.
  - Legal glyph: write hex_out slot idx, set digit_valid[idx], pulse upd_valid with upd_idx = idx and upd_hex = value.
  - Blank: clear digit_valid[idx]. hex_out slot is unchanged; no upd_valid, no code_err.
  - Illegal pattern: clear digit_valid[idx], pulse code_err. No upd_valid.
- Latency: inputs applied before edge 0 and held produce upd_valid high in the cycle after edge STABLE_CYCLES. For the default (4), that is edge 4.
- Simultaneous events: a change arriving in the cycle the window would complete wins. cnt restarts and no capture occurs.
- Slots not addressed keep their value indefinitely; there is no timeout.
- upd_valid and code_err are never high in the same cycle.

Decomposition:
- seven_seg_pkg:
  - The 16 glyph constants (active-high, gfedcba order) and SEG_BLANK.
  - Segment bit-index constants.
  - FSM state enum.
  - Shared by the existing encoder, which should be refactored to use them.
- Sub-module seven_seg2hex:
  - Purely combinational: seg_n (7) in; hex (4), legal (1) and blank (1) out.
  - Instanced once on s_q segments.
- Top level holds the sampler, counter, FSM and slot registers.

Test Plan:
- Reset release with an_n = 1110 and seg_n = ~3F held: after edge 4, upd_valid = 1 for exactly one cycle with upd_idx = 0 and upd_hex = 0. digit_valid = 0001, hex_out = 0000. No second pulse while held.
- Scan of all 16 glyphs on digit 2 (an_n = 1011), each held 6 cycles: 16 upd_valid pulses with upd_hex 0..F in order. hex_out[11:8] ends at F.
- Glitch rejection: seg_n = ~06 for 3 cycles, then ~5B held: exactly one capture, value 2, no capture of 1. The same sequence with a one-cycle change on the 4th cycle gives no capture at that point.
- Illegal and blank on digit 3, after slot 3 holds 5:
  - seg_n = ~55 held: code_err pulse, digit_valid[3] = 0.
  - Then slot 3 = 5 again, then seg_n = 7F held: digit_valid[3] = 0, no code_err, hex_out[15:12] still 5.
- Anode faults: an_n = 1111 or 1100 held 10 cycles gives no pulses and no slot changes. Then an_n = 1101 with ~66 gives capture idx 1, value 4.
- Reset asserted on the 2nd cycle of a settling window: all outputs return to 0. No capture follows until 4 fresh stable samples after reset deasserts.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: glyph table (active-high, gfedcba),
// segment bit positions and the capture FSM state type.
package seven_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_HOLD
  } cap_state_t;

endpackage

// File: rtl/seven_seg2hex.sv
// Combinational inverse of the hex-to-seven-segment encoder: maps an
// active-low segment pattern back to its hex value, flagging blank/legal.
module seven_seg2hex
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_n,
  output logic [3:0] hex,
  output logic       legal,
  output logic       blank
);

  logic [6:0] w_pat;

  assign w_pat = {~seg_n[SEG_G], ~seg_n[SEG_F], ~seg_n[SEG_E], ~seg_n[SEG_D],
                  ~seg_n[SEG_C], ~seg_n[SEG_B], ~seg_n[SEG_A]};
  assign blank = (w_pat == SEG_BLANK);

  always_comb begin
    hex   = 4'h0;
    legal = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (w_pat == GLYPH[4'(i)]) begin
        hex   = 4'(i);
        legal = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Monitors a multiplexed active-low seven-segment bus and records the hex
// value shown on each digit once its pattern has been stable long enough.
module seven_seg_capture
  import seven_seg_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   hex_out,
  output logic [DIGITS-1:0]     digit_valid,
  output logic                  upd_valid,
  output logic [2:0]            upd_idx,
  output logic [3:0]            upd_hex,
  output logic                  code_err
);

  localparam int SW = DIGITS + 7;
  // cnt counts samples beyond the first, so the window closes one step early
  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 2);

  logic [SW-1:0]     r_s_q;
  logic [SW-1:0]     r_prev;
  cap_state_t        r_state;
  logic [7:0]        r_cnt;
  logic [3:0]        r_hex [DIGITS];
  logic [DIGITS-1:0] r_dv;
  logic              r_upd_valid;
  logic [2:0]        r_upd_idx;
  logic [3:0]        r_upd_hex;
  logic              r_code_err;

  logic              w_change;
  logic [DIGITS-1:0] w_an;
  logic [3:0]        w_nlow;
  logic [2:0]        w_idx;
  logic              w_one_low;
  logic [3:0]        w_hex;
  logic              w_legal;
  logic              w_blank;

  assign w_change  = (r_s_q != r_prev);
  assign w_an      = r_s_q[SW-1:7];
  assign w_one_low = (w_nlow == 4'd1);

  always_comb begin
    w_nlow = 4'd0;
    w_idx  = 3'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!w_an[i]) begin
        w_nlow = w_nlow + 4'd1;
        w_idx  = 3'(i);
      end
    end
  end

  seven_seg2hex u_dec (
    .seg_n (r_s_q[6:0]),
    .hex   (w_hex),
    .legal (w_legal),
    .blank (w_blank)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s_q       <= '1;
      r_prev      <= '1;
      r_state     <= ST_IDLE;
      r_cnt       <= 8'd0;
      r_dv        <= '0;
      r_upd_valid <= 1'b0;
      r_upd_idx   <= 3'd0;
      r_upd_hex   <= 4'd0;
      r_code_err  <= 1'b0;
      for (int i = 0; i < DIGITS; i++) r_hex[i] <= 4'h0;
    end else begin
      r_s_q       <= {an_n, seg_n};
      r_prev      <= r_s_q;
      r_upd_valid <= 1'b0;
      r_code_err  <= 1'b0;
      if (w_change) begin
        r_cnt   <= 8'd0;
        r_state <= w_one_low ? ST_SETTLE : ST_IDLE;
      end else if (r_state == ST_SETTLE) begin
        r_cnt <= r_cnt + 8'd1;
        if (r_cnt == CNT_LAST) begin
          r_state <= ST_HOLD;
          for (int i = 0; i < DIGITS; i++) begin
            if (w_idx == 3'(i)) begin
              r_dv[i] <= w_legal;
              if (w_legal) r_hex[i] <= w_hex;
            end
          end
          if (w_legal) begin
            r_upd_valid <= 1'b1;
            r_upd_idx   <= w_idx;
            r_upd_hex   <= w_hex;
          end else if (!w_blank) begin
            r_code_err  <= 1'b1;
          end
        end
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_slot
    assign hex_out[4*g +: 4] = r_hex[g];
  end

  assign digit_valid = r_dv;
  assign upd_valid   = r_upd_valid;
  assign upd_idx     = r_upd_idx;
  assign upd_hex     = r_upd_hex;
  assign code_err    = r_code_err;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: run-length reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_seven_seg_capture;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;

  logic                clk   = 1'b0;
  logic                rst   = 1'b1;
  logic [6:0]          seg_n = 7'h7F;
  logic [DIGITS-1:0]   an_n  = '1;
  logic [4*DIGITS-1:0] hex_out;
  logic [DIGITS-1:0]   digit_valid;
  logic                upd_valid;
  logic [2:0]          upd_idx;
  logic [3:0]          upd_hex;
  logic                code_err;

  seven_seg_capture #(.DIGITS(DIGITS), .STABLE_CYCLES(STABLE)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .hex_out     (hex_out),
    .digit_valid (digit_valid),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_hex     (upd_hex),
    .code_err    (code_err)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] TB_GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a capture happens when the S-th consecutive identical
  // sample of a pattern with exactly one anode low has been taken.
  logic [4*DIGITS-1:0] m_hex;
  logic [DIGITS-1:0]   m_dv;
  logic                m_upd, m_err, m_live = 1'b0;
  logic [2:0]          m_idx;
  logic [3:0]          m_uhex;
  logic [DIGITS+6:0]   run_val;
  int                  run_len;
  int                  mlows, mpos, mval;
  logic [6:0]          mpat;

  always @(posedge clk) begin
    if (rst) begin
      m_hex = '0; m_dv = '0; m_upd = 1'b0; m_err = 1'b0;
      m_idx = 3'd0; m_uhex = 4'd0;
      run_val = '1; run_len = 1; m_live = 1'b1;
    end else begin
      m_upd = 1'b0;
      m_err = 1'b0;
      if (run_len == STABLE) begin
        mlows = 0; mpos = 0;
        for (int i = 0; i < DIGITS; i++)
          if (!run_val[7+i]) begin mlows++; mpos = i; end
        if (mlows == 1) begin
          mpat = ~run_val[6:0];
          mval = -1;
          for (int g = 0; g < 16; g++) if (TB_GLYPH[4'(g)] == mpat) mval = g;
          if (mval >= 0) begin
            m_hex[4*mpos +: 4] = 4'(mval);
            m_dv[2'(mpos)] = 1'b1;
            m_upd = 1'b1; m_idx = 3'(mpos); m_uhex = 4'(mval);
          end else begin
            m_dv[2'(mpos)] = 1'b0;
            if (mpat != 7'h00) m_err = 1'b1;
          end
        end
      end
      if ({an_n, seg_n} == run_val) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_val = {an_n, seg_n};
        run_len = 1;
      end
    end
  end

  typedef struct { logic [2:0] idx; logic [3:0] hex; } ev_t;
  ev_t q_upd [$];
  int  n_err_seen = 0;

  always @(negedge clk) begin
    if (m_live) begin
      chk("hex_out", 32'(hex_out), 32'(m_hex));
      chk("digit_valid", 32'(digit_valid), 32'(m_dv));
      chk("upd_valid", 32'(upd_valid), 32'(m_upd));
      chk("code_err", 32'(code_err), 32'(m_err));
      chk("pulse_excl", 32'(upd_valid & code_err), 32'd0);
      if (m_upd) begin
        chk("upd_idx", 32'(upd_idx), 32'(m_idx));
        chk("upd_hex", 32'(upd_hex), 32'(m_uhex));
      end
      if (upd_valid) q_upd.push_back('{idx: upd_idx, hex: upd_hex});
      if (code_err) n_err_seen++;
    end
  end

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n = an; seg_n = seg;
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hex"}, 32'(hex_out), 32'd0);
    chk({tag, "_dv"}, 32'(digit_valid), 32'd0);
    chk({tag, "_upd"}, 32'(upd_valid), 32'd0);
    chk({tag, "_idx"}, 32'(upd_idx), 32'd0);
    chk({tag, "_uhex"}, 32'(upd_hex), 32'd0);
    chk({tag, "_err"}, 32'(code_err), 32'd0);
  endtask

  logic [15:0] snap_hex;
  logic [3:0]  snap_dv;
  logic [3:0]  r_an;
  logic [6:0]  r_seg;
  logic [3:0]  gi;

  initial begin
    // Reset release with digit 0 showing '0'
    rst = 1'b1; an_n = 4'b1110; seg_n = ~7'h3F;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    q_upd.delete();
    for (int e = 0; e < 8; e++) begin
      @(negedge clk); #1;
      chk("latency_upd", 32'(upd_valid), 32'(e == 4));
      if (e == 4) begin
        chk("latency_idx", 32'(upd_idx), 32'd0);
        chk("latency_hex", 32'(upd_hex), 32'd0);
      end
    end
    chk("t1_dv", 32'(digit_valid), 32'h1);
    chk("t1_hex", 32'(hex_out), 32'h0);
    chk("t1_npulse", 32'(q_upd.size()), 32'd1);

    // All 16 glyphs on digit 2
    q_upd.delete();
    for (int g = 0; g < 16; g++) drive(4'b1011, ~TB_GLYPH[4'(g)], 6);
    chk("scan_npulse", 32'(q_upd.size()), 32'd16);
    for (int i = 0; i < 16 && i < q_upd.size(); i++) begin
      chk("scan_hex", 32'(q_upd[i].hex), 32'(i));
      chk("scan_idx", 32'(q_upd[i].idx), 32'd2);
    end
    chk("scan_slot2", 32'(hex_out[11:8]), 32'hF);

    // Glitch rejection
    q_upd.delete();
    drive(4'b1110, ~7'h06, 3);
    drive(4'b1110, ~7'h5B, 8);
    chk("glitch_n", 32'(q_upd.size()), 32'd1);
    if (q_upd.size() > 0) chk("glitch_val", 32'(q_upd[0].hex), 32'd2);
    q_upd.delete();
    drive(4'b1110, ~7'h06, 3);
    drive(4'b1110, ~7'h5B, 3);
    drive(4'b1110, ~7'h06, 1);
    drive(4'b1110, ~7'h5B, 3);
    chk("glitch2_none", 32'(q_upd.size()), 32'd0);
    drive(4'b1110, ~7'h5B, 3);
    chk("glitch2_late", 32'(q_upd.size()), 32'd1);
    if (q_upd.size() > 0) chk("glitch2_val", 32'(q_upd[0].hex), 32'd2);

    // Illegal and blank on digit 3
    drive(4'b0111, ~7'h6D, 6);
    chk("d3_hex5", 32'(hex_out[15:12]), 32'd5);
    chk("d3_dv", 32'(digit_valid[3]), 32'd1);
    n_err_seen = 0;
    q_upd.delete();
    drive(4'b0111, ~7'h55, 6);
    chk("illegal_err", 32'(n_err_seen), 32'd1);
    chk("illegal_dv", 32'(digit_valid[3]), 32'd0);
    chk("illegal_noupd", 32'(q_upd.size()), 32'd0);
    drive(4'b0111, ~7'h6D, 6);
    chk("d3_dv_again", 32'(digit_valid[3]), 32'd1);
    drive(4'b0111, 7'h7F, 6);
    chk("blank_dv", 32'(digit_valid[3]), 32'd0);
    chk("blank_err", 32'(n_err_seen), 32'd1);
    chk("blank_hex", 32'(hex_out[15:12]), 32'd5);
    chk("blank_nupd", 32'(q_upd.size()), 32'd1);

    // Anode faults
    snap_hex = hex_out;
    snap_dv  = digit_valid;
    q_upd.delete();
    n_err_seen = 0;
    drive(4'b1111, ~7'h3F, 10);
    drive(4'b1100, ~7'h3F, 10);
    chk("anode_noupd", 32'(q_upd.size()), 32'd0);
    chk("anode_noerr", 32'(n_err_seen), 32'd0);
    chk("anode_hex", 32'(hex_out), 32'(snap_hex));
    chk("anode_dv", 32'(digit_valid), 32'(snap_dv));
    drive(4'b1101, ~7'h66, 6);
    chk("anode_ok_n", 32'(q_upd.size()), 32'd1);
    if (q_upd.size() > 0) begin
      chk("anode_ok_idx", 32'(q_upd[0].idx), 32'd1);
      chk("anode_ok_hex", 32'(q_upd[0].hex), 32'd4);
    end

    // Reset in the second cycle of a settling window
    drive(4'b1110, ~7'h07, 2);
    rst = 1'b1;
    @(negedge clk); #1;
    chk_all_zero("midreset");
    rst = 1'b0;
    q_upd.delete();
    for (int e = 0; e < 8; e++) begin
      @(negedge clk); #1;
      chk("midreset_upd", 32'(upd_valid), 32'(e == 4));
      if (e == 4) chk("midreset_hex", 32'(upd_hex), 32'd7);
    end
    chk("midreset_n", 32'(q_upd.size()), 32'd1);

    // Random traffic against the model
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 99) < 3) begin
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
      end else begin
        if ($urandom_range(0, 9) < 7) r_an = ~(4'b0001 << $urandom_range(0, 3));
        else                          r_an = 4'($urandom);
        case ($urandom_range(0, 9))
          7:       r_seg = 7'h7F;
          8, 9:    r_seg = 7'($urandom);
          default: begin gi = 4'($urandom_range(0, 15)); r_seg = ~TB_GLYPH[gi]; end
        endcase
        drive(r_an, r_seg, $urandom_range(1, 7));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
